seg7_scan_mux: RTL

Parametrised time-multiplexed driver for a DIGITS-wide common-segment 7-segment display. It takes a packed hex value plus per-digit decimal points and scans one digit at a time. Dead-time between digits suppresses ghosting. Display data is double-buffered and swaps only at frame boundaries, so updates are tear-free. It sits between any binary producer (counter, UART byte, debug bus) and the board's segment/digit pins.

---
 rtl/seg7_pkg.sv | 22 ++
 rtl/seg7_hex_decode.sv | 15 +
 rtl/seg7_scan_mux.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared definitions for the multiplexed 7-segment display driver.
// Holds the hex-to-segment table, scan state type and polarity helper.
// No logic or state of its own; imported by the decoder and the scanner.
package seg7_pkg;

    typedef enum logic {
        DEAD = 1'b0,
        SHOW = 1'b1
    } seg7_state_t;

    // Segment patterns {a,b,c,d,e,f,g}, active-high, indexed by hex digit.
    localparam logic [6:0] SEG7_TABLE [16] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
        7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
    };

    function automatic logic [7:0] seg7_apply_pol(input logic [7:0] seg,
                                                  input logic       active_low);
        return active_low ? ~seg : seg;
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Hex nibble plus decimal point to active-high {dp,a,b,c,d,e,f,g} segments.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows input continuously.
// Ports: nibble (4b hex value), dp (decimal point), seg (8b segments).
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    output logic [7:0] seg
);

    assign seg = {dp, SEG7_TABLE[nibble]};

endmodule

// File: rtl/seg7_scan_mux.sv
// Time-multiplexed DIGITS-wide 7-segment scanner with dead-time and tear-free double buffering.
// Latency: outputs are registered, one cycle behind the scan FSM; new data shows after the next frame boundary.
// Backpressure: none; in_load is always accepted into the shadow register, last load before a swap wins.
// Ports: clk, rst (async active-high), in_data/in_dp/in_load (shadow write), enable,
//        out_seg {dp,a..g}, out_dig one-hot select, out_frame (pulse at end of last digit).
// Optional: define SEG7_LZ_BLANK_EN for leading-zero blanking of digits above digit 0.
module seg7_scan_mux
    import seg7_pkg::*;
#(
    parameter int DIGITS         = 4,
    parameter int CLK_DIV        = 50000,
    parameter int DEAD_CYC       = 8,
    parameter bit SEG_ACTIVE_LOW = 1'b0,
    parameter bit DIG_ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   in_data,
    input  logic [DIGITS-1:0]     in_dp,
    input  logic                  in_load,
    input  logic                  enable,
    output logic [7:0]            out_seg,
    output logic [DIGITS-1:0]     out_dig,
    output logic                  out_frame
);

    localparam int CNT_MAX = (CLK_DIV > DEAD_CYC) ? ((CLK_DIV > 2) ? CLK_DIV : 2)
                                                  : ((DEAD_CYC > 2) ? DEAD_CYC : 2);
    localparam int CW = $clog2(CNT_MAX);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    // With no dead-time the scanner never visits DEAD, so it starts (and restarts) in SHOW.
    localparam seg7_state_t START_ST = (DEAD_CYC == 0) ? SHOW : DEAD;

    localparam logic [7:0]        SEG_OFF = seg7_apply_pol(8'h00, SEG_ACTIVE_LOW);
    localparam logic [DIGITS-1:0] DIG_OFF = {DIGITS{DIG_ACTIVE_LOW}};

    seg7_state_t         state, state_d;
    logic [CW-1:0]       cnt, cnt_d;
    logic [IW-1:0]       idx, idx_d;
    logic                frame_d;

    logic [4*DIGITS-1:0] shadow_data, disp_data;
    logic [DIGITS-1:0]   shadow_dp, disp_dp;

    logic [3:0]          cur_nib;
    logic                cur_dp;
    logic [7:0]          seg_dec;
    logic [7:0]          seg_shown;
    logic                lit;

    // Scan state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= START_ST;
            cnt   <= '0;
            idx   <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            idx   <= idx_d;
        end
    end

    // Next-state: DEAD for DEAD_CYC cycles, then SHOW for CLK_DIV cycles, advance digit.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        idx_d   = idx;
        frame_d = 1'b0;
        if (!enable) begin
            state_d = START_ST;
            cnt_d   = '0;
            idx_d   = '0;
        end else if (state == DEAD) begin
            if (cnt == CW'(DEAD_CYC - 1)) begin
                cnt_d   = '0;
                state_d = SHOW;
            end else begin
                cnt_d = cnt + 1'b1;
            end
        end else begin
            if (cnt == CW'(CLK_DIV - 1)) begin
                cnt_d   = '0;
                state_d = START_ST;
                if (idx == IW'(DIGITS - 1)) begin
                    idx_d   = '0;
                    frame_d = 1'b1;
                end else begin
                    idx_d = idx + 1'b1;
                end
            end else begin
                cnt_d = cnt + 1'b1;
            end
        end
    end

    // Shadow takes every load; display only follows it on the frame edge, so the
    // value a frame is drawn from never changes part-way through that frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_data <= '0;
            shadow_dp   <= '0;
            disp_data   <= '0;
            disp_dp     <= '0;
        end else begin
            if (in_load) begin
                shadow_data <= in_data;
                shadow_dp   <= in_dp;
            end
            if (frame_d) begin
                disp_data <= shadow_data;
                disp_dp   <= shadow_dp;
            end
        end
    end

    assign cur_nib = disp_data[4*idx +: 4];
    assign cur_dp  = disp_dp[idx];

    seg7_hex_decode u_dec (
        .nibble (cur_nib),
        .dp     (cur_dp),
        .seg    (seg_dec)
    );

`ifdef SEG7_LZ_BLANK_EN
    // A digit above 0 is blank when it and every more significant nibble are zero
    // and its own decimal point is off; higher decimal points do not matter.
    logic [DIGITS-1:0] blank;
    always_comb begin
        logic zero_above;
        zero_above = 1'b1;
        blank      = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            zero_above = zero_above && (disp_data[4*k +: 4] == 4'h0);
            if (k > 0) begin
                blank[k] = zero_above && !disp_dp[k];
            end
        end
    end
    assign seg_shown = blank[idx] ? 8'h00 : seg_dec;
`else
    assign seg_shown = seg_dec;
`endif

    assign lit = enable && (state == SHOW);

    // Segments and digit select come from the same register stage, so they switch together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_seg   <= SEG_OFF;
            out_dig   <= DIG_OFF;
            out_frame <= 1'b0;
        end else begin
            out_seg   <= seg7_apply_pol(lit ? seg_shown : 8'h00, SEG_ACTIVE_LOW);
            out_dig   <= (lit ? (DIGITS'(1) << idx) : '0) ^ DIG_OFF;
            out_frame <= frame_d;
        end
    end

endmodule
